// File: rtl/r2sdf_ip_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : r2sdf_ip_sequencer_if
// Brief    : Sample-in / fixed-point-out bus of the radix-2 SDF input sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface r2sdf_ip_sequencer_if #(
    parameter int LOG2_LEN = 3
);
    logic                start;
    logic [31:0]         in_data;
    logic                in_valid;
    logic                in_ready;
    logic                out_hold;
    logic [31:0]         out_data;
    logic                out_valid;
    logic                out_first;
    logic                out_last;
    logic [LOG2_LEN-1:0] sample_idx;
    logic                flush;
    logic                frame_done;
    logic                busy;
    logic                ovf;

    // Sequencer side
    modport slave (
        input  start, in_data, in_valid, out_hold,
        output in_ready, out_data, out_valid, out_first, out_last,
               sample_idx, flush, frame_done, busy, ovf
    );

    // Producer / consumer side
    modport master (
        output start, in_data, in_valid, out_hold,
        input  in_ready, out_data, out_valid, out_first, out_last,
               sample_idx, flush, frame_done, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/r2sdf_ip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : r2sdf_ip_sequencer
// Brief    : Frame loader, Q16.16 converter and streamer feeding the first
//            radix-2 SDF FFT stage, followed by a delay-line flush window.
// Revision : 1.0 - initial release
// ============================================================================
module r2sdf_ip_sequencer #(
    parameter int LENGTH    = 8,
    parameter int LOG2_LEN  = 3,
    parameter int FRAC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    r2sdf_ip_sequencer_if.slave   bus
);

    localparam logic [LOG2_LEN-1:0] c_LAST    = LOG2_LEN'(LENGTH - 1);
    localparam logic [LOG2_LEN-1:0] c_FL_LAST = LOG2_LEN'(LENGTH - 2);
    localparam logic [LOG2_LEN-1:0] c_ONE     = LOG2_LEN'(1);
    localparam int                  c_OVF_LSB = 31 - FRAC_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_buf [LENGTH];
    logic [LOG2_LEN-1:0] r_wr_cnt;
    logic [LOG2_LEN-1:0] r_rd_cnt;
    logic [LOG2_LEN-1:0] r_fl_cnt;
    logic [LOG2_LEN-1:0] r_idx;
    logic [31:0]         r_out_data;
    logic                r_out_valid;
    logic                r_first;
    logic                r_last;
    logic                r_flush;
    logic                r_done;
    logic                r_pending;
    logic                r_ovf;

    logic                w_accept;
    logic                w_load_exit;
    logic                w_stream_due;
    logic                w_emit;
    logic                w_stall;
    logic                w_range_ovf;
    logic [31:0]         w_conv;

    assign w_accept     = (r_state == S_LOAD) && bus.in_valid;
    assign w_load_exit  = w_accept && (r_wr_cnt == c_LAST);
    // A beat is owed either on the LOAD exit edge or while the last beat has not yet been shown
    assign w_stream_due = w_load_exit || ((r_state == S_STREAM) && !r_last);
    assign w_emit       = w_stream_due && !bus.out_hold;
    assign w_stall      = w_stream_due && bus.out_hold;
    // Upper bits beyond the fpt integer field are dropped by the shift
    assign w_conv       = r_buf[r_rd_cnt] << FRAC_BITS;
    assign w_range_ovf  = !((&bus.in_data[31:c_OVF_LSB]) || !(|bus.in_data[31:c_OVF_LSB]));

    assign bus.in_ready   = (r_state == S_LOAD);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_first  = r_first;
    assign bus.out_last   = r_last;
    assign bus.sample_idx = r_idx;
    assign bus.flush      = r_flush;
    assign bus.frame_done = r_done;
    assign bus.ovf        = r_ovf;

    // Frame buffer; every entry is rewritten before it is streamed, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_cnt] <= bus.in_data;
        end
    end

    // Control FSM with registered stream/flush outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_fl_cnt    <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_flush     <= 1'b0;
            r_done      <= 1'b0;
            r_pending   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (bus.start && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (w_accept && w_range_ovf) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_wr_cnt <= r_wr_cnt + c_ONE;
                        if (r_wr_cnt == c_LAST) begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    // The last beat has been presented for one cycle; start draining
                    if (r_last) begin
                        r_state     <= S_FLUSH;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_idx       <= '0;
                        r_first     <= 1'b0;
                        r_last      <= 1'b0;
                        r_rd_cnt    <= '0;
                        r_flush     <= 1'b1;
                        r_fl_cnt    <= '0;
                        r_done      <= (LENGTH == 2);
                    end
                end
                S_FLUSH: begin
                    if (r_fl_cnt == c_FL_LAST) begin
                        r_flush   <= 1'b0;
                        r_fl_cnt  <= '0;
                        r_pending <= 1'b0;
                        r_state   <= (r_pending || bus.start) ? S_LOAD : S_IDLE;
                    end else begin
                        r_fl_cnt <= r_fl_cnt + c_ONE;
                        r_done   <= ((r_fl_cnt + c_ONE) == c_FL_LAST);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Beat emission shared by the LOAD exit edge and STREAM
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_conv;
                r_idx       <= r_rd_cnt;
                r_first     <= (r_rd_cnt == '0);
                r_last      <= (r_rd_cnt == c_LAST);
                r_rd_cnt    <= r_rd_cnt + c_ONE;
            end else if (w_stall) begin
                r_out_valid <= 1'b0;
                r_first     <= 1'b0;
                r_last      <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_r2sdf_ip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_r2sdf_ip_sequencer
// Brief    : Scoreboard bench for r2sdf_ip_sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_r2sdf_ip_sequencer;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    r2sdf_ip_sequencer_if #(.LOG2_LEN(3)) bus_if ();

    r2sdf_ip_sequencer #(.LENGTH(N), .LOG2_LEN(3), .FRAC_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic [2:0] idx; logic ovf; } beat_t;
    typedef struct { int len; int acc; } frame_t;

    beat_t  beat_q  [$];
    frame_t frame_q [$];
    int     errors = 0;
    int     checks = 0;
    int     exp_frames = 0;
    int     done_cnt = 0;
    logic   exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {21'd0, bus_if.in_ready, bus_if.out_data, bus_if.out_valid, bus_if.out_first,
                bus_if.out_last, bus_if.sample_idx, bus_if.flush, bus_if.frame_done,
                bus_if.busy, bus_if.ovf};
    endfunction

    // Reference: Q16.16 value is the integer times 2^16 kept to 32 bits
    function automatic logic [31:0] ref_conv(input logic [31:0] x);
        return x * 32'd65536;
    endfunction

    function automatic logic ref_out_of_range(input logic [31:0] x);
        return ($signed(x) > 32767) || ($signed(x) < -32768);
    endfunction

    // Loads one frame; gap_mode 0 = back-to-back, 1 = alternating valid, 2 = random valid
    task automatic load_frame(input logic [31:0] s [N], input int gap_mode, input bit do_start,
                              input int exp_len, output int rdy_cnt);
        int k = 0;
        int it = 0;
        logic v;
        rdy_cnt = 0;
        if (do_start) begin
            @(negedge clk); bus_if.start = 1'b1;
            @(negedge clk); bus_if.start = 1'b0;
        end
        while (k < N && it < 300) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (it % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus_if.in_valid = v;
            bus_if.in_data  = v ? s[k] : $urandom;
            if (bus_if.in_ready) rdy_cnt++;
            if (v && bus_if.in_ready) begin
                if (ref_out_of_range(s[k])) exp_ovf = 1'b1;
                k++;
                if (k == N) begin
                    for (int i = 0; i < N; i++) beat_q.push_back('{ref_conv(s[i]), 3'(i), exp_ovf});
                    frame_q.push_back('{exp_len, cyc});
                    exp_frames++;
                end
            end
            @(negedge clk);
            it++;
        end
        bus_if.in_valid = 1'b0;
        if (k != N) chk("load_timeout", 64'(k), 64'(N));
    endtask

    task automatic hold_at(input int hidx, input int hlen);
        int g = 0;
        while (!(bus_if.out_valid && bus_if.sample_idx == 3'(hidx)) && g < 50) begin
            @(negedge clk); g++;
        end
        if (g >= 50) chk("hold_idx_timeout", 64'(g), 64'(0));
        bus_if.out_hold = 1'b1;
        repeat (hlen) @(negedge clk);
        bus_if.out_hold = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!bus_if.frame_done && g < 100) begin
            @(negedge clk); g++;
        end
        if (g >= 100) chk("frame_done_timeout", 64'(g), 64'(0));
    endtask

    // Monitor: pops expected beats and frame timing whenever the DUT presents output
    initial begin : monitor
        beat_t  b;
        frame_t fr;
        bit     in_win = 1'b0;
        int     win_cnt = 0;
        int     flush_run = 0;
        logic [31:0] prev_data = '0;
        logic [2:0]  prev_idx = '0;
        fr = '{0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                in_win = 1'b0;
                flush_run = 0;
            end else begin
                if (bus_if.out_valid) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_beat", 64'(bus_if.out_data), 64'hDEAD);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_data", 64'(bus_if.out_data), 64'(b.data));
                        chk("beat_idx", 64'(bus_if.sample_idx), 64'(b.idx));
                        chk("beat_first", 64'(bus_if.out_first), 64'(b.idx == 3'd0));
                        chk("beat_last", 64'(bus_if.out_last), 64'(b.idx == 3'(N - 1)));
                        chk("beat_ovf", 64'(bus_if.ovf), 64'(b.ovf));
                        if (b.idx == 3'd0) begin
                            if (frame_q.size() != 0) fr = frame_q.pop_front();
                            in_win = 1'b1;
                            win_cnt = 1;
                            chk("first_latency", 64'(cyc), 64'(fr.acc + 1));
                        end else begin
                            win_cnt++;
                        end
                        if (b.idx == 3'(N - 1) && in_win) begin
                            chk("stream_len", 64'(win_cnt), 64'(fr.len));
                            in_win = 1'b0;
                        end
                    end
                    prev_data = bus_if.out_data;
                    prev_idx  = bus_if.sample_idx;
                end else if (in_win) begin
                    win_cnt++;
                    chk("hold_idx_kept", 64'(bus_if.sample_idx), 64'(prev_idx));
                    chk("hold_data_kept", 64'(bus_if.out_data), 64'(prev_data));
                end
                if (bus_if.flush) begin
                    flush_run++;
                    chk("flush_quiet", 64'({bus_if.out_valid, bus_if.out_data}), 64'(0));
                end else begin
                    flush_run = 0;
                end
                if (bus_if.frame_done) begin
                    done_cnt++;
                    chk("done_at_flush_end", 64'({bus_if.flush, 8'(flush_run)}), 64'({1'b1, 8'(N - 1)}));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] s [N];
        int rdy;
        int hl;
        int g;
        bus_if.start    = 1'b0;
        bus_if.in_data  = '0;
        bus_if.in_valid = 1'b0;
        bus_if.out_hold = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'(0));
        rst = 1'b0;

        // Back-to-back frame 1..8
        for (int i = 0; i < N; i++) s[i] = 32'(i + 1);
        load_frame(s, 0, 1'b1, N, rdy);
        chk("ready_cycles", 64'(rdy), 64'(N));
        chk("ready_low_in_stream", 64'(bus_if.in_ready), 64'(0));
        wait_done();
        @(negedge clk);
        chk("idle_after_frame", 64'(bus_if.busy), 64'(0));

        // Negative sample in range, then an out-of-range sample
        for (int i = 0; i < N; i++) s[i] = 32'(int'($urandom_range(0, 2000)) - 1000);
        s[0] = -32'sd3;
        load_frame(s, 0, 1'b1, N, rdy);
        wait_done();
        for (int i = 0; i < N; i++) s[i] = 32'(int'($urandom_range(0, 2000)) - 1000);
        s[0] = 32'd40000;
        load_frame(s, 0, 1'b1, N, rdy);
        wait_done();

        // Two-cycle hold at sample 3
        for (int i = 0; i < N; i++) s[i] = $urandom;
        load_frame(s, 0, 1'b1, N + 2, rdy);
        hold_at(3, 2);
        wait_done();

        // Start during STREAM queues the next frame; a second start is dropped
        for (int i = 0; i < N; i++) s[i] = $urandom;
        load_frame(s, 0, 1'b1, N, rdy);
        bus_if.start = 1'b1; @(negedge clk); bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1; @(negedge clk); bus_if.start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("pending_enters_load", 64'(bus_if.in_ready), 64'(1));
        for (int i = 0; i < N; i++) s[i] = $urandom;
        load_frame(s, 0, 1'b0, N, rdy);
        wait_done();
        @(negedge clk);
        chk("extra_start_dropped", 64'(bus_if.busy), 64'(0));

        // Asynchronous reset after five accepted samples
        @(negedge clk); bus_if.start = 1'b1;
        @(negedge clk); bus_if.start = 1'b0;
        g = 0;
        rdy = 0;
        while (rdy < 5 && g < 50) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = (rdy == 2) ? 32'd50000 : 32'(rdy + 100);
            if (bus_if.in_ready) rdy++;
            @(negedge clk);
            g++;
        end
        bus_if.in_valid = 1'b0;
        chk("ovf_before_reset", 64'(bus_if.ovf), 64'(1));
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 64'(0));
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) s[i] = 32'(int'($urandom_range(0, 65535)) - 32768);
        load_frame(s, 0, 1'b1, N, rdy);
        wait_done();

        // Alternating in_valid during LOAD
        for (int i = 0; i < N; i++) s[i] = 32'(int'($urandom_range(0, 65535)) - 32768);
        load_frame(s, 1, 1'b1, N, rdy);
        wait_done();

        // Randomized frames with random gaps and holds
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++)
                s[i] = ($urandom_range(0, 3) == 0) ? $urandom
                                                    : 32'(int'($urandom_range(0, 65535)) - 32768);
            hl = $urandom_range(0, 3);
            load_frame(s, 2, 1'b1, N + hl, rdy);
            if (hl != 0) hold_at($urandom_range(0, N - 2), hl);
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("frames_completed", 64'(done_cnt), 64'(exp_frames));
        chk("beats_drained", 64'(beat_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
